// File: rtl/ob_ingress_q.sv
// ob_ingress_q: ingress command FIFO in front of the order-book controller.
// Commands arrive over a valid/ready handshake. The oldest entry is held in a
// registered show-ahead head (ingress_vld/ingress_cmd) and is popped by
// ingress_consume. Every output is registered or decoded directly from
// registered pointers, so there is no combinational in->out path.
module ob_ingress_q #(
    parameter int W        = 64,
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_vld,
    input  logic [W-1:0]             in_cmd,
    output logic                     in_rdy,
    output logic                     ingress_vld,
    output logic [W-1:0]             ingress_cmd,
    input  logic                     ingress_consume,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     almost_full,
    output logic                     err_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt, occ_nxt;
    logic          push, pop;
    logic          head_vld_nxt;
    logic [W-1:0]  head_cmd_nxt;

    // Handshakes only qualify on registered flags, so a pop never frees a
    // slot for a push in the same cycle, and a consume while the queue is
    // empty has no effect.
    assign push = in_vld & in_rdy;
    assign pop  = ingress_consume & ingress_vld;

    // Pointers carry one extra wrap bit, so the difference spans 0..DEPTH.
    assign occupancy  = wr_ptr - rd_ptr;
    assign occ_nxt    = occupancy + PW'(push) - PW'(pop);
    assign rd_ptr_nxt = rd_ptr + PW'(pop);

    // Next head: the entry at the post-pop read pointer. If that slot is the
    // one being written on this edge (the queue is empty, or it drains to the
    // incoming push), the value is taken straight from in_cmd.
    always_comb begin
        head_vld_nxt = (occ_nxt != '0);
        head_cmd_nxt = ingress_cmd;
        if (head_vld_nxt) begin
            if (rd_ptr_nxt == wr_ptr)
                head_cmd_nxt = in_cmd;
            else
                head_cmd_nxt = mem[rd_ptr_nxt[AW-1:0]];
        end
    end

    // Storage array. It has no reset because validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= in_cmd;
    end

    // Pointers, the registered flags, the head register and the sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            in_rdy        <= 1'b0;
            ingress_vld   <= 1'b0;
            ingress_cmd   <= '0;
            almost_full   <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr + PW'(push);
            rd_ptr      <= rd_ptr_nxt;
            in_rdy      <= (occ_nxt < PW'(DEPTH));
            almost_full <= (occ_nxt >= PW'(AFULL_TH));
            ingress_vld <= head_vld_nxt;
            ingress_cmd <= head_cmd_nxt;
            if (ingress_consume && !ingress_vld)
                err_underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ob_ingress_q.sv
// Directed table-driven bench for ob_ingress_q (W=64, DEPTH=8, AFULL_TH=6).
module tb_ob_ingress_q;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic [63:0] in_cmd = '0;
    logic        in_rdy;
    logic        ingress_vld;
    logic [63:0] ingress_cmd;
    logic        ingress_consume = 1'b0;
    logic [3:0]  occupancy;
    logic        almost_full;
    logic        err_underflow;

    int checks = 0;
    int failures = 0;

    ob_ingress_q #(.W(64), .DEPTH(8), .AFULL_TH(6)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_cmd(in_cmd), .in_rdy(in_rdy),
        .ingress_vld(ingress_vld), .ingress_cmd(ingress_cmd),
        .ingress_consume(ingress_consume),
        .occupancy(occupancy), .almost_full(almost_full),
        .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [63:0] ic;
        logic        cons;
        logic        rdy;
        logic        vld;
        logic [63:0] cmd;
        logic [3:0]  occ;
        logic        af;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic iv, logic [63:0] ic, logic cons,
                                logic rdy, logic vld, logic [63:0] cmd,
                                logic [3:0] occ, logic af);
        vec_t v;
        v.iv = iv; v.ic = ic; v.cons = cons;
        v.rdy = rdy; v.vld = vld; v.cmd = cmd; v.occ = occ; v.af = af;
        tbl.push_back(v);
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic rdy, logic vld, logic [63:0] cmd,
                           logic [3:0] occ, logic af, logic err);
        chk({tag, "_rdy"}, 64'(in_rdy), 64'(rdy));
        chk({tag, "_vld"}, 64'(ingress_vld), 64'(vld));
        if (vld) chk({tag, "_cmd"}, ingress_cmd, cmd);
        chk({tag, "_occ"}, 64'(occupancy), 64'(occ));
        chk({tag, "_af"}, 64'(almost_full), 64'(af));
        chk({tag, "_err"}, 64'(err_underflow), 64'(err));
    endtask

    task automatic step(logic iv, logic [63:0] ic, logic cons);
        in_vld = iv; in_cmd = ic; ingress_consume = cons;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   iv ic     cons rdy vld cmd    occ af
        add(0, 64'h0,  0,   1,  0,  64'h0,  0, 0);  // first edge after reset
        add(1, 64'h11, 0,   1,  1,  64'h11, 1, 0);
        add(1, 64'h22, 0,   1,  1,  64'h11, 2, 0);
        add(1, 64'h33, 0,   1,  1,  64'h11, 3, 0);
        add(0, 64'h0,  0,   1,  1,  64'h11, 3, 0);  // head stable
        add(0, 64'h0,  1,   1,  1,  64'h22, 2, 0);
        add(0, 64'h0,  1,   1,  1,  64'h33, 1, 0);
        add(0, 64'h0,  1,   1,  0,  64'h0,  0, 0);
        add(1, 64'h1,  0,   1,  1,  64'h1,  1, 0);  // fill to DEPTH
        add(1, 64'h2,  0,   1,  1,  64'h1,  2, 0);
        add(1, 64'h3,  0,   1,  1,  64'h1,  3, 0);
        add(1, 64'h4,  0,   1,  1,  64'h1,  4, 0);
        add(1, 64'h5,  0,   1,  1,  64'h1,  5, 0);
        add(1, 64'h6,  0,   1,  1,  64'h1,  6, 1);
        add(1, 64'h7,  0,   1,  1,  64'h1,  7, 1);
        add(1, 64'h8,  0,   0,  1,  64'h1,  8, 1);
        add(1, 64'h9,  0,   0,  1,  64'h1,  8, 1);  // 9th held, refused
        add(1, 64'h9,  1,   1,  1,  64'h2,  7, 1);  // pop, still refused
        add(1, 64'h9,  0,   0,  1,  64'h2,  8, 1);  // now accepted
        add(0, 64'h0,  1,   1,  1,  64'h3,  7, 1);
        add(0, 64'h0,  1,   1,  1,  64'h4,  6, 1);
        add(0, 64'h0,  1,   1,  1,  64'h5,  5, 0);
        add(0, 64'h0,  1,   1,  1,  64'h6,  4, 0);
        add(0, 64'h0,  1,   1,  1,  64'h7,  3, 0);
        add(0, 64'h0,  1,   1,  1,  64'h8,  2, 0);
        add(0, 64'h0,  1,   1,  1,  64'h9,  1, 0);
        add(1, 64'hAA, 1,   1,  1,  64'hAA, 1, 0);  // push+pop at occ 1
        add(1, 64'hBB, 0,   1,  1,  64'hAA, 2, 0);
        add(1, 64'hCC, 1,   1,  1,  64'hBB, 2, 0);  // push+pop at occ 2
        add(0, 64'h0,  1,   1,  1,  64'hCC, 1, 0);
        add(0, 64'h0,  1,   1,  0,  64'h0,  0, 0);

        // Reset state while rst is held low.
        #2;
        chk_all("reset", 0, 0, 64'h0, 0, 0, 0);
        chk("reset_cmd", ingress_cmd, 64'h0);
        #10 rst = 1'b1;  // release between edges
        #1;
        chk("rdy_before_edge", 64'(in_rdy), 64'h0);

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].ic, tbl[i].cons);
            chk_all($sformatf("v%0d", i), tbl[i].rdy, tbl[i].vld, tbl[i].cmd,
                    tbl[i].occ, tbl[i].af, 1'b0);
        end

        // Consume while empty: no pointer movement, sticky error.
        step(0, 64'h0, 1);
        chk_all("uf", 1, 0, 64'h0, 0, 0, 1);
        step(0, 64'h0, 0);
        step(0, 64'h0, 0);
        chk_all("uf_hold", 1, 0, 64'h0, 0, 0, 1);
        step(1, 64'hDD, 0);
        chk_all("uf_push", 1, 1, 64'hDD, 1, 0, 1);

        // Fill to five entries, then reset asynchronously mid-cycle.
        for (int k = 0; k < 4; k++) step(1, 64'hE0 + 64'(k), 0);
        chk_all("pre_rst", 1, 1, 64'hDD, 5, 0, 1);
        in_vld = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 64'h0, 0, 0, 0);
        chk("async_rst_cmd", ingress_cmd, 64'h0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk_all("post_rst", 1, 0, 64'h0, 0, 0, 0);
        step(1, 64'h5A, 0);
        chk_all("post_rst_push", 1, 1, 64'h5A, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
